// File: rtl/irom_arbiter_if.sv
// Bus bundle between the fetch unit, the secondary read port, the IROM and
// the arbiter that shares the ROM between them.
interface irom_arbiter_if #(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 12
);
  logic                  IFUReq;
  logic                  IFUStall;
  logic [XLEN-1:0]       IFUAdr;
  logic [XLEN-1:0]       IFURdData;
  logic                  IFUArbStall;
  logic                  LSUReq;
  logic [XLEN-1:0]       LSUAdr;
  logic                  LSUGnt;
  logic                  LSURdValid;
  logic [XLEN-1:0]       LSURdData;
  logic                  ROMce;
  logic [ADDR_WIDTH-1:0] ROMAdr;
  logic [XLEN-1:0]       ROMDout;

  // Arbiter side
  modport slave (
    input  IFUReq, IFUStall, IFUAdr, LSUReq, LSUAdr, ROMDout,
    output IFURdData, IFUArbStall, LSUGnt, LSURdValid, LSURdData, ROMce, ROMAdr
  );

  // Requester / ROM side
  modport master (
    output IFUReq, IFUStall, IFUAdr, LSUReq, LSUAdr, ROMDout,
    input  IFURdData, IFUArbStall, LSUGnt, LSURdValid, LSURdData, ROMce, ROMAdr
  );
endinterface

// File: rtl/irom_arbiter.sv
// Shares a single-port, 1-cycle synchronous IROM between instruction fetch
// (default priority) and a secondary load/debug read port. The LSU gets a
// forced grant after MAX_WAIT consecutive denied cycles. The last fetch word
// is held and replayed so IFURdData only changes after an IFU grant.
module irom_arbiter #(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  irom_arbiter_if.slave  bus
);

  localparam int OFF = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  owner_t                r_owner;
  owner_t                w_owner_nxt;
  logic [XLEN-1:0]       r_hold;
  logic [7:0]            r_wait_cnt;

  logic                  w_ifu_live;
  logic                  w_forced;
  logic                  w_lsu_win;
  logic                  w_ifu_win;
  logic [ADDR_WIDTH-1:0] w_ifu_wadr;
  logic [ADDR_WIDTH-1:0] w_lsu_wadr;
  logic                  w_unused_adr;

  assign w_ifu_live   = bus.IFUReq & ~bus.IFUStall;
  assign w_forced     = (r_wait_cnt == 8'(MAX_WAIT));
  assign w_lsu_win    = bus.LSUReq & (~w_ifu_live | w_forced);
  assign w_ifu_win    = w_ifu_live & ~w_lsu_win;
  assign w_ifu_wadr   = bus.IFUAdr[ADDR_WIDTH+OFF-1:OFF];
  assign w_lsu_wadr   = bus.LSUAdr[ADDR_WIDTH+OFF-1:OFF];
  // Byte offset and upper address bits are intentionally ignored here.
  assign w_unused_adr = ^{bus.IFUAdr, bus.LSUAdr};

  // Owner state register: remembers who owns the ROM output next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_owner <= OWN_NONE;
    else          r_owner <= w_owner_nxt;
  end

  // Next owner is simply this cycle's grant.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_lsu_win)      w_owner_nxt = OWN_LSU;
    else if (w_ifu_win) w_owner_nxt = OWN_IFU;
  end

  // Grant outputs this cycle and read return for last cycle's owner.
  always_comb begin
    bus.LSUGnt      = 1'b0;
    bus.IFUArbStall = 1'b0;
    bus.ROMce       = 1'b0;
    bus.ROMAdr      = '0;
    bus.LSURdValid  = 1'b0;
    bus.LSURdData   = '0;
    bus.IFURdData   = r_hold;
    // Grant-side outputs are forced low while reset is held.
    if (reset_n) begin
      bus.LSUGnt      = w_lsu_win;
      bus.IFUArbStall = w_lsu_win & w_ifu_live;
      bus.ROMce       = w_lsu_win | w_ifu_win;
      bus.ROMAdr      = w_lsu_win ? w_lsu_wadr : w_ifu_wadr;
    end
    case (r_owner)
      OWN_IFU: bus.IFURdData = bus.ROMDout;
      OWN_LSU: begin
        bus.LSURdValid = 1'b1;
        bus.LSURdData  = bus.ROMDout;
      end
      default: ;
    endcase
  end

  // Capture every fetch word so it can be replayed after an LSU steal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_hold <= '0;
    else if (r_owner == OWN_IFU) r_hold <= bus.ROMDout;
  end

  // Count consecutive denied LSU cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_wait_cnt <= 8'd0;
    else if (w_lsu_win || !bus.LSUReq)    r_wait_cnt <= 8'd0;
    else if (!w_forced)                   r_wait_cnt <= r_wait_cnt + 8'd1;
  end

endmodule

// File: tb/tb_irom_arbiter.sv
// Bench for irom_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level model.
module tb_irom_arbiter;

  localparam int XLEN = 64;
  localparam int AW   = 12;
  localparam int MW   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  irom_arbiter_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

  irom_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ROM contents: word k holds 0x1000 + k, registered output.
  always @(posedge clk) if (bus.ROMce) bus.ROMDout <= 64'h1000 + 64'(bus.ROMAdr);

  int total = 0;
  int bad   = 0;

  // Reference model state: one in-flight read and the last fetched word.
  int          m_flight;   // 0 none, 1 fetch, 2 secondary
  logic [63:0] m_fdata;
  logic [63:0] m_last;
  int          m_denied;   // consecutive denied secondary cycles
  bit          m_lgnt;
  bit          m_stl;

  typedef struct {
    logic        ireq;
    logic        istall;
    logic [63:0] iadr;
    logic        lreq;
    logic [63:0] ladr;
    logic        gnt;
    logic        stl;
    logic        ce;
    logic [11:0] adr;
    logic [63:0] ifurd;
    logic        lvld;
    logic [63:0] ldata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [63:0] badr);
    return (badr >> 3) & 64'hFFF;
  endfunction

  task automatic model_reset();
    m_flight = 0; m_fdata = '0; m_last = '0; m_denied = 0; m_lgnt = 0; m_stl = 0;
  endtask

  // Drive one cycle, compare against the model, then advance the model.
  task automatic cycle(input logic ireq, input logic istall, input logic [63:0] iadr,
                       input logic lreq, input logic [63:0] ladr);
    bit live, lwin, iwin;
    logic [63:0] e_ifurd, e_ldata, e_adr;
    bit e_vld;
    @(negedge clk);
    bus.IFUReq = ireq; bus.IFUStall = istall; bus.IFUAdr = iadr;
    bus.LSUReq = lreq; bus.LSUAdr = ladr;
    #1;
    live = ireq && !istall;
    lwin = lreq && (!live || m_denied >= MW);
    iwin = live && !lwin;
    e_adr = lwin ? word_of(ladr) : word_of(iadr);
    e_vld = 0; e_ldata = '0; e_ifurd = m_last;
    if (m_flight == 1) begin e_ifurd = m_fdata; m_last = m_fdata; end
    else if (m_flight == 2) begin e_vld = 1; e_ldata = m_fdata; end
    chk("m_gnt",   64'(bus.LSUGnt), 64'(lwin));
    chk("m_stall", 64'(bus.IFUArbStall), 64'(lwin && live));
    chk("m_ce",    64'(bus.ROMce), 64'(lwin || iwin));
    chk("m_adr",   64'(bus.ROMAdr), e_adr);
    chk("m_ifurd", bus.IFURdData, e_ifurd);
    chk("m_lvld",  64'(bus.LSURdValid), 64'(e_vld));
    chk("m_ldata", bus.LSURdData, e_ldata);
    m_flight = lwin ? 2 : (iwin ? 1 : 0);
    m_fdata  = 64'h1000 + e_adr;
    m_denied = (lwin || !lreq) ? 0 : ((m_denied < MW) ? m_denied + 1 : MW);
    m_lgnt = lwin;
    m_stl  = lwin && live;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_ifurd"}, bus.IFURdData, 64'h0);
    chk({nm, "_lvld"},  64'(bus.LSURdValid), 64'h0);
    chk({nm, "_gnt"},   64'(bus.LSUGnt), 64'h0);
    chk({nm, "_stall"}, 64'(bus.IFUArbStall), 64'h0);
    chk({nm, "_ce"},    64'(bus.ROMce), 64'h0);
    chk({nm, "_adr"},   64'(bus.ROMAdr), 64'h0);
  endtask

  initial begin
    logic [63:0] fa;
    bit lpend;
    logic [63:0] lpadr;

    vecs[0] = '{1'b1, 1'b0, 64'h00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b1, 12'd0, 64'h0,    1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 64'h08, 1'b0, 64'h00, 1'b0, 1'b0, 1'b1, 12'd1, 64'h1000, 1'b0, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h10, 1'b0, 64'h00, 1'b0, 1'b0, 1'b1, 12'd2, 64'h1001, 1'b0, 64'h0};
    vecs[3] = '{1'b0, 1'b0, 64'h10, 1'b1, 64'h20, 1'b1, 1'b0, 1'b1, 12'd4, 64'h1002, 1'b0, 64'h0};
    vecs[4] = '{1'b0, 1'b0, 64'h18, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 12'd3, 64'h1002, 1'b1, 64'h1004};
    vecs[5] = '{1'b0, 1'b0, 64'h18, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 12'd3, 64'h1002, 1'b0, 64'h0};

    // Reset state with requests present.
    bus.IFUReq = 1'b1; bus.IFUStall = 1'b0; bus.IFUAdr = 64'h88;
    bus.LSUReq = 1'b1; bus.LSUAdr = 64'h48;
    model_reset();
    repeat (2) @(negedge clk);
    #1 all_zero("reset");
    bus.IFUReq = 1'b0; bus.LSUReq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: fetch-only then a secondary read while idle.
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].ireq, vecs[i].istall, vecs[i].iadr, vecs[i].lreq, vecs[i].ladr);
      chk($sformatf("v%0d_gnt", i),   64'(bus.LSUGnt),      64'(vecs[i].gnt));
      chk($sformatf("v%0d_stall", i), 64'(bus.IFUArbStall), 64'(vecs[i].stl));
      chk($sformatf("v%0d_ce", i),    64'(bus.ROMce),       64'(vecs[i].ce));
      chk($sformatf("v%0d_adr", i),   64'(bus.ROMAdr),      64'(vecs[i].adr));
      chk($sformatf("v%0d_ifurd", i), bus.IFURdData,        vecs[i].ifurd);
      chk($sformatf("v%0d_lvld", i),  64'(bus.LSURdValid),  64'(vecs[i].lvld));
      chk($sformatf("v%0d_ldata", i), bus.LSURdData,        vecs[i].ldata);
    end

    // Starvation: continuous fetch, secondary request held until granted.
    fa = 64'h200;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, fa, (i < 5), 64'h100);
      chk($sformatf("starve%0d_gnt", i),   64'(bus.LSUGnt),      64'(i == 4));
      chk($sformatf("starve%0d_stall", i), 64'(bus.IFUArbStall), 64'(i == 4));
      if (i == 5) begin
        chk("starve_ret_ifurd", bus.IFURdData, 64'h1043);
        chk("starve_ret_ldata", bus.LSURdData, 64'h1020);
      end
      if (i == 6) chk("starve_resume", bus.IFURdData, 64'h1044);
      if (i != 4) fa = fa + 64'h8;
    end
    chk("starve_waitcnt", 64'(dut.r_wait_cnt), 64'h0);

    // Fetch stalled while a secondary read arrives.
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, 1'b1, fa, (j == 0), 64'h300);
      chk($sformatf("fstall%0d_gnt", j),   64'(bus.LSUGnt),      64'(j == 0));
      chk($sformatf("fstall%0d_stall", j), 64'(bus.IFUArbStall), 64'h0);
      chk($sformatf("fstall%0d_ifurd", j), bus.IFURdData,        64'h1046);
      if (j == 1) chk("fstall_ldata", bus.LSURdData, 64'h1060);
    end

    // Reset right after a secondary grant drops the in-flight read.
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 64'h3F8);
    chk("rst_pre_gnt", 64'(bus.LSUGnt), 64'h1);
    @(posedge clk);
    reset_n = 1'b0;
    #1 all_zero("rst_async");
    repeat (2) begin
      @(negedge clk);
      #1 all_zero("rst_hold");
    end
    bus.LSUReq = 1'b0; bus.IFUReq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1 chk("rst_rel_ifurd", bus.IFURdData, 64'h0);
    chk("rst_rel_lvld", 64'(bus.LSURdValid), 64'h0);
    cycle(1'b1, 1'b0, 64'h38, 1'b0, 64'h0);
    cycle(1'b0, 1'b0, 64'h38, 1'b0, 64'h0);
    chk("rst_first_fetch", bus.IFURdData, 64'h1007);

    // Randomized traffic; secondary address held stable until granted.
    lpend = 0; lpadr = '0;
    for (int n = 0; n < 400; n++) begin
      if (!lpend && ($urandom_range(0, 99) < 40)) begin
        lpend = 1; lpadr = {$urandom, $urandom};
      end
      cycle(($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 20),
            {$urandom, $urandom}, lpend, lpadr);
      if (m_lgnt) lpend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/irom_arbiter.md
Name: irom_arbiter

Overview:
- Shares the single-port, 1-cycle synchronous instruction ROM between two requesters.
- The instruction fetch port (IFU) has priority by default.
- A secondary XLEN-wide read port serves load/debug reads of the IROM region.
- The block drives the ROM chip enable and word address, returns read data to whichever requester owns the read, and replays the last fetch word to the IFU whenever the ROM output was used by the other requester.

Parameters:
- XLEN, 64, data/address width; legal values are 32 or 64.
- ADDR_WIDTH, 12, ROM word-address width.
- MAX_WAIT, 4, consecutive denied cycles after which the LSU request gets forced priority for one grant; legal range 1..255.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- IFUReq  in  1  fetch wants a new word this cycle
- IFUStall  in  1  fetch pipeline frozen; no new fetch is needed and the output must hold
- IFUAdr  in  XLEN  next fetch byte address
- IFURdData  out  XLEN  fetch word; valid the cycle after an IFU grant, held otherwise
- IFUArbStall  out  1  arbiter stole the ROM from a live IFU request; fetch must stall
- LSUReq  in  1  secondary read request; must stay high with a stable address until granted
- LSUAdr  in  XLEN  secondary read byte address
- LSUGnt  out  1  secondary request granted this cycle
- LSURdValid  out  1  LSURdData valid; one-cycle pulse
- LSURdData  out  XLEN  secondary read data
- ROMce  out  1  ROM chip enable
- ROMAdr  out  ADDR_WIDTH  ROM word address
- ROMDout  in  XLEN  ROM read data; registered inside the ROM, valid the cycle after ROMce

Behaviour:
- Definitions:
  - OFF = log2(XLEN/8).
  - The word address is Adr[ADDR_WIDTH+OFF-1:OFF] of the selected requester.
  - IFULive = IFUReq & ~IFUStall.
- Grant (combinational, per cycle):
  - LSU wins if LSUReq & (~IFULive | WaitCnt == MAX_WAIT).
  - Otherwise the IFU wins if IFULive.
  - Otherwise there is no grant.
- Outputs for each grant case:
  - LSU win: LSUGnt = 1. IFUArbStall = IFULive.
  - IFU win: LSUGnt = 0. IFUArbStall = 0.
  - ROMce = (IFU grant) | (LSU grant). ROMAdr follows the granted requester and is the IFU address when there is no grant.
- Owner register, 2-bit state: NONE / IFU / LSU.
  - Loaded every cycle with the current grant.
  - Reset value: NONE.
- Read return, all in the cycle after a grant:
  - Owner == IFU: IFURdData = ROMDout, and HoldReg <= ROMDout.
  - Owner == LSU: LSURdValid = 1 and LSURdData = ROMDout. IFURdData = HoldReg.
  - Owner == NONE: IFURdData = HoldReg. LSURdValid = 0.
- Read-return invariant: IFURdData never changes except in the cycle following an IFU grant. This keeps the hold-when-stalled semantics of the fetch path.
- LSURdData is don't-care when LSURdValid = 0 and is driven to 0 to ease debug.
- WaitCnt, width 8:
  - Increments, saturating at MAX_WAIT, in each cycle with LSUReq & ~LSUGnt.
  - Clears on LSUGnt or ~LSUReq.
  - Reset value: 0.
- Fairness: back-to-back LSU requests under continuous fetch are granted at most every MAX_WAIT+1 cycles. The IFU is stalled only for the forced grant cycle.
- Simultaneous events:
  - The LSU can be granted two cycles in a row only if IFULive is 0.
  - A grant and a return of the previous read in the same cycle are normal; latency is fixed at 1 and fully pipelined.
- Reset (asynchronous, mid-operation included): all outputs go immediately to 0, i.e. IFURdData, HoldReg, LSURdValid, LSUGnt, IFUArbStall, ROMce and ROMAdr.
  - An LSU read in flight at reset is dropped; LSURdValid is never asserted for it.
  - The first cycle after reset release behaves as owner NONE.
- XLEN = 32 and 64 behave identically; only OFF changes. Sub-word and halfword selection stays in the fetch path.

Test Plan:
- Fetch only: IFUReq = 1, IFUAdr = 0x0, 0x8, 0x10 on consecutive cycles with ROM word k = 0x1000+k. Required: ROMAdr = 0, 1, 2 and IFURdData = 0x1000, 0x1001, 0x1002 one cycle later. LSUGnt is never asserted.
- LSU while idle: IFUReq = 0, LSUReq = 1, LSUAdr = 0x20. Required: LSUGnt = 1 the same cycle, then LSURdValid = 1 with LSURdData = 0x1004. IFURdData keeps its last value and IFUArbStall = 0.
- Starvation, MAX_WAIT = 4: continuous IFULive with LSUReq held. Required: LSUGnt exactly on the 5th request cycle with IFUArbStall = 1 that cycle only. IFURdData repeats HoldReg in the return cycle, then fetch resumes. WaitCnt ends at 0.
- IFUStall = 1 with LSUReq = 1. Required: immediate LSU grant, IFUArbStall = 0, and IFURdData constant throughout the stall.
- Assert reset_n = 0 the cycle after an LSU grant. Required: LSURdValid stays 0, all outputs are 0 asynchronously, and after release the first IFU grant returns correct data.
